// File: rtl/fpadd_arb_pkg.sv
// fpadd_arb_pkg: shared types and helpers for the shared FP adder sequencer.
// Holds the sequencer state encoding, IEEE-754 single-precision field widths
// and a signed-zero detector used by the optional zero bypass.
package fpadd_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int FP_W     = 32;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   // True for +0 and -0: every bit except the sign is clear.
   function automatic logic is_zero_x40(input logic [FP_W-1:0] bits);
      return (bits[FP_EXP_W+FP_MAN_W-1:0] == '0);
   endfunction

endpackage

// File: rtl/rr_arb_x40.sv
// rr_arb_x40: combinational round-robin grant.
// The request vector is rotated so the pointer position becomes bit 0, a
// lowest-set-bit priority chain picks the winner, and the one-hot result is
// rotated back. The pointer register itself lives in the parent.
module rr_arb_x40 #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_x40,
   input  logic [IDW-1:0]  ptr_x40,
   output logic [NREQ-1:0] grant_x40,
   output logic [IDW-1:0]  win_x40,
   output logic            any_x40
);

   logic [NREQ-1:0]           req_rot;
   logic [NREQ-1:0]           grant_rot;
   logic [NREQ:0]             lower_any;
   logic [NREQ:0][IDW-1:0]    win_acc;
   logic [IDW:0]              back_sh;

   // Rotate right by the pointer: bit j of req_rot is requester (ptr+j) mod NREQ.
   assign req_rot = NREQ'({req_x40, req_x40} >> ptr_x40);

   // Rotating left by ptr equals rotating right by NREQ-ptr on a doubled vector.
   assign back_sh   = (IDW+1)'(NREQ) - (IDW+1)'(ptr_x40);
   assign grant_x40 = NREQ'({grant_rot, grant_rot} >> back_sh);

   assign lower_any[0] = 1'b0;
   assign win_acc[0]   = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_pri
         // First set bit in rotated order wins; later bits are masked.
         assign grant_rot[gi]   = req_rot[gi] & ~lower_any[gi];
         assign lower_any[gi+1] = lower_any[gi] | req_rot[gi];
         // One-hot to index encoder over the unrotated grant.
         assign win_acc[gi+1]   = win_acc[gi] | (grant_x40[gi] ? IDW'(gi) : '0);
      end
   endgenerate

   assign win_x40 = win_acc[NREQ];
   assign any_x40 = lower_any[NREQ];

endmodule

// File: rtl/fpadd_share_arb.sv
// fpadd_share_arb: shares one external combinational FP32 adder among NREQ
// requesters. A round-robin winner's operands are registered onto the adder
// inputs, the adder is given ADD_CYC cycles to settle, and the sum is returned
// on a single valid/ready response channel tagged with the requester id.
// Optional build macro FPADD_ZERO_BYPASS_EN: when either operand is +/-0 the
// other operand is returned directly one cycle after the grant.
module fpadd_share_arb
   import fpadd_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ADD_CYC = 2,
   parameter int IDW     = $clog2(NREQ)
) (
   input  logic                 clk_x40,
   input  logic                 rst_n_x40,
   input  logic [NREQ-1:0]      req_valid_x40,
   output logic [NREQ-1:0]      req_ready_x40,
   input  logic [FP_W*NREQ-1:0] req_a_x40,
   input  logic [FP_W*NREQ-1:0] req_b_x40,
   output logic [FP_W-1:0]      add_a_x40,
   output logic [FP_W-1:0]      add_b_x40,
   input  logic [FP_W-1:0]      add_sum_x40,
   output logic                 rsp_valid_x40,
   input  logic                 rsp_ready_x40,
   output logic [FP_W-1:0]      rsp_sum_x40,
   output logic [IDW-1:0]       rsp_id_x40
);

   localparam int              CNT_W    = (ADD_CYC > 1) ? $clog2(ADD_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_CYC - 1);

   state_t             state_reg, state_next;
   logic [IDW-1:0]     ptr_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [FP_W-1:0]    add_a_reg, add_b_reg, rsp_sum_reg;
   logic [IDW-1:0]     rsp_id_reg;
   logic               rsp_valid_reg;

   logic [NREQ-1:0]    grant;
   logic [IDW-1:0]     win;
   logic               any_req;
   logic               grant_fire;
   logic               bypass;
   logic [FP_W-1:0]    bypass_sum;
   logic [FP_W-1:0]    win_a, win_b;
   logic [FP_W-1:0]    a_arr [NREQ];
   logic [FP_W-1:0]    b_arr [NREQ];

   rr_arb_x40 #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_arb (
      .req_x40   (req_valid_x40),
      .ptr_x40   (ptr_reg),
      .grant_x40 (grant),
      .win_x40   (win),
      .any_x40   (any_req)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a_x40[gi*FP_W +: FP_W];
         assign b_arr[gi] = req_b_x40[gi*FP_W +: FP_W];
      end
   endgenerate

   assign win_a = a_arr[win];
   assign win_b = b_arr[win];

`ifdef FPADD_ZERO_BYPASS_EN
   // A zero operand makes the sum equal to the other operand, so skip the adder.
   assign bypass     = is_zero_x40(win_a) | is_zero_x40(win_b);
   assign bypass_sum = is_zero_x40(win_a) ? win_b : win_a;
`else
   assign bypass     = 1'b0;
   assign bypass_sum = win_a;
`endif

   // State register.
   always_ff @(posedge clk_x40 or negedge rst_n_x40) begin
      if (!rst_n_x40) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode and the combinational request handshake.
   always_comb begin
      state_next    = state_reg;
      req_ready_x40 = '0;
      grant_fire    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               req_ready_x40 = grant;
               grant_fire    = 1'b1;
               state_next    = bypass ? RESP : EXEC;
            end
         end
         EXEC: begin
            if (cnt_reg == '0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_x40) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, settle countdown, sum capture and response handshake.
   always_ff @(posedge clk_x40 or negedge rst_n_x40) begin
      if (!rst_n_x40) begin
         ptr_reg       <= '0;
         cnt_reg       <= '0;
         add_a_reg     <= '0;
         add_b_reg     <= '0;
         rsp_sum_reg   <= '0;
         rsp_id_reg    <= '0;
         rsp_valid_reg <= 1'b0;
      end else if (grant_fire) begin
         add_a_reg  <= win_a;
         add_b_reg  <= win_b;
         rsp_id_reg <= win;
         ptr_reg    <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
         cnt_reg    <= CNT_LOAD;
         if (bypass) begin
            rsp_sum_reg   <= bypass_sum;
            rsp_valid_reg <= 1'b1;
         end
      end else if (state_reg == EXEC) begin
         if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end else begin
            rsp_sum_reg   <= add_sum_x40;
            rsp_valid_reg <= 1'b1;
         end
      end else if ((state_reg == RESP) && rsp_ready_x40) begin
         rsp_valid_reg <= 1'b0;
      end
   end

   assign add_a_x40     = add_a_reg;
   assign add_b_x40     = add_b_reg;
   assign rsp_sum_x40   = rsp_sum_reg;
   assign rsp_id_x40    = rsp_id_reg;
   assign rsp_valid_x40 = rsp_valid_reg;

endmodule

// File: tb/tb_fpadd_share_arb.sv
// tb_fpadd_share_arb: directed, table-driven bench for fpadd_share_arb.
// The external adder is stood in for by a lookup of hand-computed sums.
module tb_fpadd_share_arb;

   localparam int NREQ    = 4;
   localparam int ADD_CYC = 2;
   localparam int IDW     = 2;
   localparam int LAT     = ADD_CYC + 1;
`ifdef FPADD_ZERO_BYPASS_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = ADD_CYC + 1;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_a, req_b;
   logic [31:0]          add_a, add_b, add_sum;
   logic                 rsp_valid, rsp_ready;
   logic [31:0]          rsp_sum;
   logic [IDW-1:0]       rsp_id;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int last_grant_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fpadd_share_arb #(
      .NREQ    (NREQ),
      .ADD_CYC (ADD_CYC),
      .IDW     (IDW)
   ) dut (
      .clk_x40       (clk),
      .rst_n_x40     (rst_n),
      .req_valid_x40 (req_valid),
      .req_ready_x40 (req_ready),
      .req_a_x40     (req_a),
      .req_b_x40     (req_b),
      .add_a_x40     (add_a),
      .add_b_x40     (add_b),
      .add_sum_x40   (add_sum),
      .rsp_valid_x40 (rsp_valid),
      .rsp_ready_x40 (rsp_ready),
      .rsp_sum_x40   (rsp_sum),
      .rsp_id_x40    (rsp_id)
   );

   // Stand-in combinational adder: hand-computed sums for the operand pairs used.
   function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         64'h42C40000_43290000: return 32'h43858000; //  98 + 169 = 267
         64'h42C60000_C2B20000: return 32'h41200000; //  99 + -89 = 10
         64'hC2340000_429E0000: return 32'h42080000; // -45 + 79  = 34
         64'h00000000_C2EA0000: return 32'hC2EA0000; //  0 + -117
         64'h00000000_00000000: return 32'h00000000; //  0 + 0
         64'h42C40000_80000000: return 32'h42C40000; //  98 + -0
         64'h80000000_43290000: return 32'h43290000; //  -0 + 169
         default:               return 32'h7FC00000;
      endcase
   endfunction

   assign add_sum = fp_model(add_a, add_b);

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sum;
      int          lat;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
      req_a[32*idx +: 32] = a;
      req_b[32*idx +: 32] = b;
      req_valid[idx]      = 1'b1;
   endtask

   // Waits (bounded) for any req_ready, then checks it against the expected grant.
   task automatic wait_grant(input logic [NREQ-1:0] exp_oh, input string name);
      int n = 0;
      #1;
      while (req_ready == '0 && n < 30) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk(name, 32'(req_ready), 32'(exp_oh));
      last_grant_cyc = cyc;
   endtask

   // Called just after the grant edge; counts edges until rsp_valid appears.
   task automatic wait_rsp(output int lat);
      int n = 1;
      while (!rsp_valid && n < 30) begin
         tick();
         n++;
      end
      lat = n;
   endtask

   task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_sum, input int exp_lat, input string tag);
      int lat;
      set_req(idx, a, b);
      wait_grant(NREQ'(1) << idx, {tag, "_grant"});
      tick();
      req_valid[idx] = 1'b0;
      wait_rsp(lat);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_sum"}, rsp_sum, exp_sum);
      chk({tag, "_id"}, 32'(rsp_id), 32'(idx));
      $display("txn %s req=%0d a=%h b=%h sum=%h id=%0d lat=%0d", tag, idx, a, b, rsp_sum, rsp_id, lat);
      tick();
      chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'(0));
      chk({tag, "_add_a_hold"}, add_a, a);
      chk({tag, "_add_b_hold"}, add_b, b);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat;
      int prev;
      logic [31:0] held_sum;
      logic        seen;

      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;

      vecs[0] = '{0, 32'h42C40000, 32'h43290000, 32'h43858000, LAT};
      vecs[1] = '{3, 32'h42C60000, 32'hC2B20000, 32'h41200000, LAT};
      vecs[2] = '{1, 32'h00000000, 32'hC2EA0000, 32'hC2EA0000, ZLAT};
      vecs[3] = '{2, 32'h00000000, 32'h00000000, 32'h00000000, ZLAT};
      vecs[4] = '{3, 32'h42C40000, 32'h80000000, 32'h42C40000, ZLAT};
      vecs[5] = '{0, 32'h80000000, 32'h43290000, 32'h43290000, ZLAT};

      // Reset state
      repeat (2) tick();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_add_a", add_a, 32'h0);
      chk("rst_rsp_sum", rsp_sum, 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'(0));
      rst_n = 1'b1;
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'(0));

      // All four requesters valid at once: rotating grants 4 cycles apart
      for (int k = 0; k < NREQ; k++) set_req(k, 32'h42C60000, 32'hC2B20000);
      prev = 0;
      for (int k = 0; k < NREQ; k++) begin
         wait_grant(NREQ'(1) << k, $sformatf("all4_grant%0d", k));
         if (k > 0) chk($sformatf("all4_spacing%0d", k), 32'(last_grant_cyc - prev), 32'(ADD_CYC + 2));
         prev = last_grant_cyc;
         tick();
         req_valid[k] = 1'b0;
         wait_rsp(lat);
         chk($sformatf("all4_latency%0d", k), 32'(lat), 32'(LAT));
         chk($sformatf("all4_sum%0d", k), rsp_sum, 32'h41200000);
         chk($sformatf("all4_id%0d", k), 32'(rsp_id), 32'(k));
         $display("txn all4 req=%0d sum=%h id=%0d lat=%0d", k, rsp_sum, rsp_id, lat);
      end
      tick();

      // Table-driven single operations
      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].lat, $sformatf("vec%0d", i));
      end

      // Round robin: grant 1, then req0 and req2 together -> 2 first, then 0
      do_op(1, 32'h42C40000, 32'h43290000, 32'h43858000, LAT, "rr_pre");
      set_req(0, 32'hC2340000, 32'h429E0000);
      set_req(2, 32'hC2340000, 32'h429E0000);
      wait_grant(4'b0100, "rr_first");
      tick();
      req_valid[2] = 1'b0;
      wait_rsp(lat);
      chk("rr_first_sum", rsp_sum, 32'h42080000);
      chk("rr_first_id", 32'(rsp_id), 32'(2));
      $display("txn rr req=2 sum=%h id=%0d lat=%0d", rsp_sum, rsp_id, lat);
      wait_grant(4'b0001, "rr_second");
      tick();
      req_valid[0] = 1'b0;
      wait_rsp(lat);
      chk("rr_second_sum", rsp_sum, 32'h42080000);
      chk("rr_second_id", 32'(rsp_id), 32'(0));
      $display("txn rr req=0 sum=%h id=%0d lat=%0d", rsp_sum, rsp_id, lat);
      tick();

      // Backpressure: response held for 5 cycles with a competing request pending
      rsp_ready = 1'b0;
      set_req(3, 32'h42C40000, 32'h43290000);
      wait_grant(4'b1000, "bp_grant");
      tick();
      req_valid[3] = 1'b0;
      wait_rsp(lat);
      chk("bp_latency", 32'(lat), 32'(LAT));
      held_sum = 32'h43858000;
      chk("bp_sum", rsp_sum, held_sum);
      set_req(0, 32'h42C60000, 32'hC2B20000);
      for (int c = 0; c < 5; c++) begin
         tick();
         #1;
         chk($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'(1));
         chk($sformatf("bp_sum%0d", c), rsp_sum, held_sum);
         chk($sformatf("bp_id%0d", c), 32'(rsp_id), 32'(3));
         chk($sformatf("bp_ready%0d", c), 32'(req_ready), 32'(0));
      end
      $display("txn bp req=3 sum=%h id=%0d held=5", rsp_sum, rsp_id);
      rsp_ready = 1'b1;
      tick();
      chk("bp_release", 32'(rsp_valid), 32'(0));
      wait_grant(4'b0001, "bp_next_grant");
      chk("bp_next_cycle", 32'(last_grant_cyc - cyc), 32'(0));
      tick();
      req_valid[0] = 1'b0;
      wait_rsp(lat);
      chk("bp_next_sum", rsp_sum, 32'h41200000);
      $display("txn bp_next req=0 sum=%h id=%0d lat=%0d", rsp_sum, rsp_id, lat);
      tick();

      // Reset asserted mid-EXEC discards the op and resets the pointer
      set_req(2, 32'h42C60000, 32'hC2B20000);
      wait_grant(4'b0100, "rx_grant");
      tick();
      req_valid[2] = 1'b0;
      chk("rx_add_a_loaded", add_a, 32'h42C60000);
      #1 rst_n = 1'b0;
      #1;
      chk("rx_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rx_add_a", add_a, 32'h0);
      chk("rx_add_b", add_b, 32'h0);
      chk("rx_rsp_sum", rsp_sum, 32'h0);
      chk("rx_rsp_id", 32'(rsp_id), 32'(0));
      chk("rx_req_ready", 32'(req_ready), 32'(0));
      repeat (2) tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      chk("rx_no_response", 32'(seen), 32'(0));
      $display("txn reset_mid_exec req=2 discarded");
      set_req(0, 32'hC2340000, 32'h429E0000);
      set_req(3, 32'h42C40000, 32'h43290000);
      wait_grant(4'b0001, "rx_ptr_reset");
      tick();
      req_valid[0] = 1'b0;
      wait_rsp(lat);
      chk("rx_after_sum", rsp_sum, 32'h42080000);
      $display("txn rx_after req=0 sum=%h id=%0d lat=%0d", rsp_sum, rsp_id, lat);
      wait_grant(4'b1000, "rx_then3");
      tick();
      req_valid[3] = 1'b0;
      wait_rsp(lat);
      chk("rx_then3_sum", rsp_sum, 32'h43858000);
      chk("rx_then3_id", 32'(rsp_id), 32'(3));
      $display("txn rx_then req=3 sum=%h id=%0d lat=%0d", rsp_sum, rsp_id, lat);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fpadd_share_arb.md
Name: fpadd_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational single-precision IEEE-754 adder (fpadd_unpipe) among NREQ requesters.
- Registers the winning operand pair onto the adder inputs and waits a fixed settle time.
- Captures the sum and returns it on a single response channel, tagged with the requester id.
- Sits between the FP compute clients and the unpipelined adder, which is instantiated outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADD_CYC, 2, clock cycles allowed for the combinational adder to settle (>=1).
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk_x40  in  1  clock, rising edge.
- rst_n_x40  in  1  reset, asynchronous, active-low.
- req_valid_x40  in  NREQ  per-requester request valid.
- req_ready_x40  out  NREQ  per-requester accept; one-hot or zero.
- req_a_x40  in  32*NREQ  operand A, slice i belongs to requester i.
- req_b_x40  in  32*NREQ  operand B, slice i belongs to requester i.
- add_a_x40  out  32  registered operand A to the adder.
- add_b_x40  out  32  registered operand B to the adder.
- add_sum_x40  in  32  adder result.
- rsp_valid_x40  out  1  response valid.
- rsp_ready_x40  in  1  response accept.
- rsp_sum_x40  out  32  registered sum.
- rsp_id_x40  out  IDW  requester index that owns rsp_sum_x40.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; add_a/add_b/rsp_sum = 0; rsp_id = 0; rsp_valid = 0; req_ready = 0; rr pointer = 0 (requester 0 highest priority); settle counter = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, pick the first valid index searching from the rr pointer upward with wrap.
  - req_ready[win] = 1 combinationally in that cycle; this is the handshake.
  - On the edge: add_a/add_b <= winner operands; rsp_id <= win; pointer <= (win+1) mod NREQ; counter <= ADD_CYC-1; go to EXEC.
  - No valid: stay in IDLE; pointer unchanged.
- EXEC: req_ready = 0.
  - Counter > 0: decrement.
  - Counter == 0: rsp_sum <= add_sum; rsp_valid <= 1; go to RESP.
- RESP: rsp_valid = 1; outputs held stable.
  - On rsp_valid && rsp_ready: rsp_valid <= 0 and go to IDLE. New requests are granted in the following cycle, not the same one.
- Latency: handshake in cycle T gives rsp_valid in cycle T+ADD_CYC+1. Throughput is one op per ADD_CYC+2 cycles with rsp_ready tied high.
- Requesters hold valid and operands stable until ready. Dropping valid before the grant is legal; nothing is recorded.
- add_a/add_b hold the last operands until the next grant, so the adder input does not toggle.
- Backpressure: rsp_ready low in RESP stalls indefinitely; req_ready stays 0 for every requester.
- Reset asserted mid-EXEC or mid-RESP: the transaction is discarded, no response is issued, and all registers return to reset values.
- The block does no arithmetic; the sum is passed bit-exact from the adder.

Optional Feature:
- Macro: FPADD_ZERO_BYPASS_EN.
- Defined:
  - At grant in IDLE, if operand A is ±0 (bits[30:0]==0), rsp_sum <= B; else if B is ±0, rsp_sum <= A.
  - On a bypass, rsp_valid <= 1 and the FSM goes directly to RESP, so latency is 1 cycle.
  - add_a/add_b are still loaded.
- Undefined: every op goes through EXEC.

Decomposition:
- Package fpadd_arb_pkg:
  - State enum {IDLE, EXEC, RESP}.
  - Localparams FP_W=32, FP_EXP_W=8, FP_MAN_W=23.
  - Function is_zero_x40(bits).
- Sub-module rr_arb_x40: NREQ-wide round-robin grant from the request vector and pointer.
  - Outputs a one-hot grant plus an encoded index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single op: req0 A=0x42C40000 (98), B=0x43290000 (169), ADD_CYC=2, rsp_ready=1 -> req_ready[0] in cycle 0; rsp_valid in cycle 3 with sum 0x43858000, id 0.
- All 4 valid after reset, operands (99,-89): 0x42C60000/0xC2B20000 -> grants 0,1,2,3 in order, each spaced 4 cycles; every response has sum 0x41200000 and the matching id.
- Round-robin: after granting 1, raise req0 and req2 together with A=0xC2340000 (-45), B=0x429E0000 (79) -> req2 granted first, then req0; both sums 0x42080000.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_sum and rsp_id stable, rsp_valid stays 1, req_ready = 0; completes one cycle after rsp_ready rises.
- Reset mid-EXEC: drop rst_n_x40 during EXEC -> all outputs 0 immediately, no response after release, next grant goes to req0.
- Zero operands: A=0x00000000, B=0xC2EA0000 (-117) -> with FPADD_ZERO_BYPASS_EN, rsp_valid 1 cycle after grant with sum 0xC2EA0000; without it, 3 cycles with the same value. 0+0 gives 0x00000000.
